// File: rtl/cache_controller.sv
// cache_controller: direct-mapped, write-through, no-write-allocate cache
// sitting between a single CPU request port and a block-oriented main memory.
//
// Optional feature: define CACHE_STATS_EN to add saturating read hit/miss
// counters (hit_count, miss_count). Without it those ports do not exist.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   cpu_req/we/addr/wdata   CPU request, held stable until cpu_ready
//   cpu_rdata, cpu_ready    read data and one-cycle completion pulse
//   add, write_data         main-memory word address / write word
//   mem_read, mem_write     main-memory commands (mutually exclusive)
//   read_data               4-word memory block, word n at [n*DATA_WIDTH +: DATA_WIDTH]
//   ready_to_read, finished_writing   registered memory completion flags
//   hit_count, miss_count   (CACHE_STATS_EN only) read hit/miss counters
module cache_controller #(
    parameter int ADD_WIDTH  = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LINES      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADD_WIDTH-1:0]    cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_ready,
    output logic [ADD_WIDTH-1:0]    add,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic                    mem_read,
    output logic                    mem_write,
    input  logic [4*DATA_WIDTH-1:0] read_data,
    input  logic                    ready_to_read,
    input  logic                    finished_writing
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]             hit_count,
    output logic [15:0]             miss_count
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADD_WIDTH - IDX_W - 2;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

    state_t                  state;
    logic                    first;     // first cycle of a FILL/WRITE visit
    logic [ADD_WIDTH-1:0]    req_addr;  // request latched when leaving IDLE
    logic [LINES-1:0]        valid;
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [DATA_WIDTH-1:0]   data_mem [LINES][4];

    // Address fields of the live CPU request (used in IDLE) and of the
    // latched request (used while the memory access is in flight).
    logic [TAG_W-1:0] c_tag, r_tag;
    logic [IDX_W-1:0] c_idx, r_idx;
    logic [1:0]       c_off, r_off;

    assign {c_tag, c_idx, c_off} = cpu_addr;
    assign {r_tag, r_idx, r_off} = req_addr;

    logic hit_c, hit_r, fill_en, wr_en;

    assign hit_c = valid[c_idx] && (tag_mem[c_idx] == c_tag);
    assign hit_r = valid[r_idx] && (tag_mem[r_idx] == r_tag);

    // Completion flags are stale in the first command cycle, so they are
    // only honoured once 'first' has cleared.
    assign fill_en = (state == FILL)  && !first && ready_to_read;
    assign wr_en   = (state == WRITE) && !first && finished_writing && hit_r;

    // Tag/data storage carries no reset; the valid bits alone gate hits.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[r_idx] <= r_tag;
            for (int w = 0; w < 4; w++)
                data_mem[r_idx][w] <= read_data[w*DATA_WIDTH +: DATA_WIDTH];
        end else if (wr_en) begin
            data_mem[r_idx][r_off] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            first      <= 1'b0;
            req_addr   <= '0;
            valid      <= '0;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            add        <= '0;
            write_data <= '0;
`ifdef CACHE_STATS_EN
            hit_count  <= '0;
            miss_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cpu_ready <= 1'b0;
                    if (cpu_req) begin
                        req_addr <= cpu_addr;
                        first    <= 1'b1;
                        if (cpu_we) begin
                            // write-through: memory always updated, no allocate
                            mem_write  <= 1'b1;
                            add        <= cpu_addr;
                            write_data <= cpu_wdata;
                            state      <= WRITE;
                        end else if (hit_c) begin
                            cpu_rdata <= data_mem[c_idx][c_off];
                            cpu_ready <= 1'b1;
                            state     <= RESP;
                        end else begin
                            mem_read <= 1'b1;
                            add      <= {c_tag, c_idx, 2'b00};
                            state    <= FILL;
                        end
`ifdef CACHE_STATS_EN
                        if (!cpu_we) begin
                            if (hit_c && hit_count != 16'hFFFF)
                                hit_count <= hit_count + 16'd1;
                            if (!hit_c && miss_count != 16'hFFFF)
                                miss_count <= miss_count + 16'd1;
                        end
`endif
                    end
                end
                FILL: begin
                    if (first) begin
                        first <= 1'b0;
                    end else if (ready_to_read) begin
                        valid[r_idx] <= 1'b1;
                        cpu_rdata    <= read_data[r_off*DATA_WIDTH +: DATA_WIDTH];
                        mem_read     <= 1'b0;
                        cpu_ready    <= 1'b1;
                        state        <= RESP;
                    end
                end
                WRITE: begin
                    if (first) begin
                        first <= 1'b0;
                    end else if (finished_writing) begin
                        mem_write <= 1'b0;
                        cpu_ready <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    cpu_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
